// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// MUL_DIV_MADD_EN (see mul_div_unit) enables the OP_MADD/OP_MADDU encodings.
package mul_div_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;

    // Iteration counter width for a given iteration count.
    function automatic int unsigned cnt_width(input int unsigned iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/mul_div_abs.sv
// Conditional two's-complement negation: magnitude on operand entry, sign restore in FIX.
module mul_div_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MUL_DIV_MADD_EN to enable MADD/MADDU (64-bit accumulate into {hi,lo}).
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned      CNT_W    = cnt_width(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d, done_q, done_d, dz_q, dz_d;

    logic op_legal, op_div, op_signed;
`ifdef MUL_DIV_MADD_EN
    logic op_madd, madd_q, madd_d;
`endif

    always_comb begin
        op_legal  = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
`ifdef MUL_DIV_MADD_EN
        op_madd   = 1'b0;
`endif
        case (op)
            OP_MULT:  begin op_legal = 1'b1; op_signed = 1'b1; end
            OP_MULTU: op_legal = 1'b1;
            OP_DIV:   begin op_legal = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
            OP_DIVU:  begin op_legal = 1'b1; op_div = 1'b1; end
`ifdef MUL_DIV_MADD_EN
            OP_MADD:  begin op_legal = 1'b1; op_signed = 1'b1; op_madd = 1'b1; end
            OP_MADDU: begin op_legal = 1'b1; op_madd = 1'b1; end
`endif
            default:  ;
        endcase
    end

    logic [WIDTH-1:0] a_mag, b_mag;

    mul_div_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value  (a),
        .negate (op_signed & a[WIDTH-1]),
        .result (a_mag)
    );

    mul_div_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (b),
        .negate (op_signed & b[WIDTH-1]),
        .result (b_mag)
    );

    // One iteration step. Multiply: acc_lo holds the multiplier, product shifts in from the top.
    // Divide: acc_lo holds dividend bits shifting out and quotient bits shifting in.
    logic [WIDTH:0]   mul_sum, mul_add, div_shift, div_diff;
    logic [WIDTH-1:0] calc_hi, calc_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        mul_add   = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            calc_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            calc_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            calc_hi = mul_add[WIDTH:1];
            calc_lo = {mul_add[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mul_div_abs #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .value  ({acc_hi_q, acc_lo_q}),
        .negate (neg_res_q),
        .result (prod_fix)
    );

    mul_div_abs #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (acc_lo_q),
        .negate (neg_res_q),
        .result (quo_fix)
    );

    mul_div_abs #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_hi_q),
        .negate (neg_rem_q),
        .result (rem_fix)
    );

`ifdef MUL_DIV_MADD_EN
    logic [2*WIDTH-1:0] madd_sum;
    assign madd_sum = {hi_q, lo_q} + prod_fix;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
`ifdef MUL_DIV_MADD_EN
        madd_d    = madd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && op_legal) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = op_div ? a_mag : b_mag;
                    opnd_d    = op_div ? b_mag : a_mag;
                    is_div_d  = op_div;
                    neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op_signed & a[WIDTH-1];
                    b_zero_d  = (b == '0);
                    dz_d      = 1'b0;
`ifdef MUL_DIV_MADD_EN
                    madd_d    = op_madd;
`endif
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            ST_CALC: begin
                acc_hi_d = calc_hi;
                acc_lo_d = calc_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = b_zero_q ? '1 : quo_fix;
                    dz_d = b_zero_q;
`ifdef MUL_DIV_MADD_EN
                end else if (madd_q) begin
                    {hi_d, lo_d} = madd_sum;
`endif
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUL_DIV_MADD_EN
            madd_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
`ifdef MUL_DIV_MADD_EN
            madd_q    <= madd_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (honours MUL_DIV_MADD_EN).
module tb_mul_div_unit;

    localparam logic [2:0] T_MULT  = 3'd0;
    localparam logic [2:0] T_MULTU = 3'd1;
    localparam logic [2:0] T_DIV   = 3'd2;
    localparam logic [2:0] T_DIVU  = 3'd3;
    localparam logic [2:0] T_MADD  = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .start    (start),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    // Issue one operation, scramble operands after acceptance, wait for done with a bound.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic dz_e0);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
        dz_e0 = div_zero;
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_one_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic dz;

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dz);
        chk("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'd7, dz);
        chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("div_neg", T_DIV, 32'hFFFF_FFF9, 32'd2, dz);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("divu", T_DIVU, 32'd7, 32'd2, dz);
        chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

        run_op("div_zero", T_DIV, 32'h1234_5678, 32'd0, dz);
        chk("div_zero_hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        chk("div_zero_flag", 64'(div_zero), 64'd1);

        run_op("mult_after_dz", T_MULT, 32'd2, 32'd3, dz);
        chk("dz_cleared_at_start", 64'(dz), 64'd0);
        chk("mult_after_dz_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

        run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dz);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI/MTLO while idle: both in one cycle, then LO alone.
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        wr_hi = 1'b0; wdata = 32'h5555_5555;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mt_hilo", {hi, lo}, 64'hAAAA_AAAA_5555_5555);

        // Illegal op is ignored.
        @(negedge clk);
        op = 3'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("illegal_op_busy", 64'(busy), 64'd0);

        // Busy-time start/write are dropped; reset aborts without a HI/LO write.
        @(negedge clk);
        op = T_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        op = T_DIVU; a = 32'd9; b = 32'd3; start = 1'b1; wr_lo = 1'b1; wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        start = 1'b0; wr_lo = 1'b0;
        chk("busy_start_ignored", 64'(busy), 64'd1);
        chk("busy_wr_dropped", {hi, lo}, 64'hAAAA_AAAA_5555_5555);
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("multu_small", T_MULTU, 32'd6, 32'd7, dz);
        chk("multu_small_hilo", {hi, lo}, 64'd42);

        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b0; wdata = 32'd0;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'd5;
        @(negedge clk);
        wr_lo = 1'b0;
`ifdef MUL_DIV_MADD_EN
        run_op("madd", T_MADD, 32'd2, 32'd3, dz);
        chk("madd_hilo", {hi, lo}, 64'd11);
        run_op("madd_neg", T_MADD, 32'hFFFF_FFFF, 32'd1, dz);
        chk("madd_neg_hilo", {hi, lo}, 64'd10);
`else
        @(negedge clk);
        op = T_MADD; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("madd_off_busy", 64'(busy), 64'd0);
        repeat (35) @(posedge clk);
        #1;
        chk("madd_off_hilo", {hi, lo}, 64'd5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
